// File: rtl/commit_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : commit_unit_if
// Description : Bundles the ROB head fields, the register-file write port, the
//               store-buffer release handshake and the flush/trap outputs of
//               the commit unit into a single interface.
//               modport master : the commit unit (drives the commit outputs)
//               modport slave  : the ROB / pipeline side (drives the head fields)
//               Optional macro COMMIT_PERF_EN adds the retired_count and
//               flush_count performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface commit_unit_if #(
  parameter int ROB_IDX_W = 4
) ();

  // ROB head status and fields
  logic                 empty;
  logic                 head_ready;
  logic                 ROB_head_store;
  logic [1:0]           head_itype;
  logic [4:0]           head_rd;
  logic [31:0]          head_value;
  logic [31:0]          head_pc;
  logic [31:0]          head_target;
  logic                 head_branch_result;
  logic                 head_exception;
  logic [7:0]           head_mcause;
  logic [ROB_IDX_W-1:0] head_rob;

  // Commit results
  logic                 rd_en;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [31:0]          rf_wdata;
  logic [ROB_IDX_W-1:0] rf_wrob;

  // Store-buffer release handshake
  logic                 st_req;
  logic                 st_ack;
  logic                 st_err;

  // Exception / redirect
  logic                 illegal_access_e;
  logic                 flush;
  logic [31:0]          redirect_pc;
  logic [31:0]          trap_mepc;
  logic [7:0]           trap_mcause;

`ifdef COMMIT_PERF_EN
  logic [63:0]          retired_count;
  logic [31:0]          flush_count;
`endif

  modport master (
    input  empty, head_ready, ROB_head_store, head_itype, head_rd, head_value,
           head_pc, head_target, head_branch_result, head_exception,
           head_mcause, head_rob, st_ack, st_err,
    output rd_en, rf_we, rf_waddr, rf_wdata, rf_wrob, st_req,
           illegal_access_e, flush, redirect_pc, trap_mepc, trap_mcause
`ifdef COMMIT_PERF_EN
    , output retired_count, flush_count
`endif
  );

  modport slave (
    output empty, head_ready, ROB_head_store, head_itype, head_rd, head_value,
           head_pc, head_target, head_branch_result, head_exception,
           head_mcause, head_rob, st_ack, st_err,
    input  rd_en, rf_we, rf_waddr, rf_wdata, rf_wrob, st_req,
           illegal_access_e, flush, redirect_pc, trap_mepc, trap_mcause
`ifdef COMMIT_PERF_EN
    , input retired_count, flush_count
`endif
  );

endinterface
`default_nettype wire

// File: rtl/commit_unit.sv
`default_nettype none
// ============================================================================
// Module      : commit_unit
// Description : In-order commit stage. Retires at most one ROB head entry per
//               cycle: writes the architectural register file, releases
//               stores through the store-buffer handshake, squashes the
//               pipeline on branch mispredicts and takes traps on exceptions.
// Ports       : clk    - clock, all state changes on the rising edge
//               reset  - asynchronous active-high reset
//               bus    - commit_unit_if.master (ROB head in, commit results,
//                        store handshake, flush/redirect and trap values out)
// Parameters  : TRAP_VECTOR - fetch redirect target when a trap is taken
//               ROB_IDX_W   - ROB index width (must match the interface)
// Options     : COMMIT_PERF_EN - adds retired_count / flush_count counters
// Revision    : 1.0 - initial release
// ============================================================================
module commit_unit #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int          ROB_IDX_W   = 4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  commit_unit_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_WAIT = 2'd1,
    FLUSH   = 2'd2,
    TRAP    = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_flush;
  logic [31:0]          r_redirect_pc;
  logic [31:0]          r_trap_mepc;
  logic [7:0]           r_trap_mcause;

  logic                 w_head_valid;
  logic                 w_take_trap;
  logic                 w_take_store;
  logic                 w_retire_idle;
  logic                 w_mispredict;
  logic                 w_rf_we;
  logic                 w_st_req;
  logic                 w_illegal;
  logic                 w_rd_en;
  logic [ROB_IDX_W-1:0] w_head_rob;

  assign w_head_rob = bus.head_rob;

  // Decode of the head entry. Exceptions win over the store flag and the
  // itype decode, so an excepting entry never writes rf nor requests a store.
  always_comb begin
    w_head_valid  = !bus.empty && bus.head_ready;
    w_take_trap   = (r_state == IDLE) && w_head_valid && bus.head_exception;
    w_take_store  = (r_state == IDLE) && w_head_valid && !bus.head_exception
                    && bus.ROB_head_store;
    w_retire_idle = (r_state == IDLE) && w_head_valid && !bus.head_exception
                    && !bus.ROB_head_store;
    w_mispredict  = w_retire_idle && (bus.head_itype == 2'b00)
                    && bus.head_branch_result;
    // Writes to x0 are dropped but the entry still retires.
    w_rf_we       = w_retire_idle && bus.head_itype[1] && (bus.head_rd != 5'd0);
    // st_req follows the state so an asynchronous reset removes it at once.
    w_st_req      = (r_state == ST_WAIT);
    w_illegal     = (r_state == ST_WAIT) && bus.st_ack && bus.st_err;
    w_rd_en       = w_take_trap || w_retire_idle
                    || ((r_state == ST_WAIT) && bus.st_ack && !bus.st_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_flush       <= 1'b0;
      r_redirect_pc <= 32'd0;
      r_trap_mepc   <= 32'd0;
      r_trap_mcause <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_flush <= 1'b0;
          if (w_take_trap) begin
            r_state       <= TRAP;
            r_flush       <= 1'b1;
            r_redirect_pc <= TRAP_VECTOR;
            r_trap_mepc   <= bus.head_pc;
            r_trap_mcause <= bus.head_mcause;
          end else if (w_take_store) begin
            r_state <= ST_WAIT;
          end else if (w_mispredict) begin
            r_state       <= FLUSH;
            r_flush       <= 1'b1;
            r_redirect_pc <= bus.head_target;
          end
        end
        // On an error ack the head stays in the ROB; it comes back from IDLE
        // as an exception once the ROB has marked it.
        ST_WAIT: begin
          if (bus.st_ack) begin
            r_state <= IDLE;
          end
        end
        FLUSH, TRAP: begin
          r_flush <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_flush <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rd_en            = w_rd_en;
  assign bus.rf_we            = w_rf_we;
  assign bus.rf_waddr         = bus.head_rd;
  assign bus.rf_wdata         = bus.head_value;
  assign bus.rf_wrob          = w_head_rob;
  assign bus.st_req           = w_st_req;
  assign bus.illegal_access_e = w_illegal;
  assign bus.flush            = r_flush;
  assign bus.redirect_pc      = r_redirect_pc;
  assign bus.trap_mepc        = r_trap_mepc;
  assign bus.trap_mcause      = r_trap_mcause;

`ifdef COMMIT_PERF_EN
  logic [63:0] r_retired_count;
  logic [31:0] r_flush_count;

  // Both counters wrap naturally at their width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retired_count <= 64'd0;
      r_flush_count   <= 32'd0;
    end else begin
      if (w_rd_en) begin
        r_retired_count <= r_retired_count + 64'd1;
      end
      if (r_flush) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign bus.retired_count = r_retired_count;
  assign bus.flush_count   = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_unit
// Description : Self-checking bench for commit_unit: table of single-cycle
//               head vectors, directed multi-cycle sequences (mispredict
//               flush, delayed store ack, store error followed by trap, reset
//               during a store wait) and a randomized run checked against a
//               behavioural model. Honours COMMIT_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_unit;

  localparam logic [31:0] TV = 32'h0000_0100;

  logic clk;
  logic reset;

  commit_unit_if #(.ROB_IDX_W(4)) bus ();

  commit_unit #(.TRAP_VECTOR(TV), .ROB_IDX_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_wait;      // a store is waiting for its ack
  bit          m_flush;     // this cycle is the squash cycle
  logic [31:0] m_redirect, m_mepc;
  logic [7:0]  m_mcause;
  longint unsigned m_retired;
  int unsigned     m_flushes;

  bit e_rd_en, e_rf_we, e_st_req, e_ill, e_flush;
  // next-state values computed together with the outputs
  bit          n_wait, n_flush;
  logic [31:0] n_redirect, n_mepc;
  logic [7:0]  n_mcause;

  task automatic model_reset();
    m_wait = 0; m_flush = 0; m_redirect = 0; m_mepc = 0; m_mcause = 0;
    m_retired = 0; m_flushes = 0;
  endtask

  task automatic model_eval();
    e_rd_en = 0; e_rf_we = 0; e_st_req = 0; e_ill = 0; e_flush = m_flush;
    n_wait = m_wait; n_flush = 0;
    n_redirect = m_redirect; n_mepc = m_mepc; n_mcause = m_mcause;
    if (m_flush) begin
      // squash cycle: nothing retires
    end else if (m_wait) begin
      e_st_req = 1;
      if (bus.st_ack) begin
        n_wait = 0;
        if (bus.st_err) e_ill = 1;
        else e_rd_en = 1;
      end
    end else if (!bus.empty && bus.head_ready) begin
      if (bus.head_exception) begin
        e_rd_en = 1; n_flush = 1; n_redirect = TV;
        n_mepc = bus.head_pc; n_mcause = bus.head_mcause;
      end else if (bus.ROB_head_store) begin
        n_wait = 1;
      end else begin
        e_rd_en = 1;
        e_rf_we = bus.head_itype[1] && (bus.head_rd != 0);
        if (bus.head_itype == 2'b00 && bus.head_branch_result) begin
          n_flush = 1; n_redirect = bus.head_target;
        end
      end
    end
  endtask

  // Compare every output to the model, advance the model, move to next cycle.
  task automatic step();
    model_eval();
    chk("rd_en", bus.rd_en, e_rd_en);
    chk("rf_we", bus.rf_we, e_rf_we);
    if (e_rf_we) begin
      chk("rf_waddr", bus.rf_waddr, bus.head_rd);
      chk("rf_wdata", bus.rf_wdata, bus.head_value);
      chk("rf_wrob", bus.rf_wrob, bus.head_rob);
    end
    chk("st_req", bus.st_req, e_st_req);
    chk("illegal_access_e", bus.illegal_access_e, e_ill);
    chk("flush", bus.flush, e_flush);
    chk("redirect_pc", bus.redirect_pc, m_redirect);
    chk("trap_mepc", bus.trap_mepc, m_mepc);
    chk("trap_mcause", bus.trap_mcause, m_mcause);
`ifdef COMMIT_PERF_EN
    chk("retired_count", bus.retired_count, m_retired);
    chk("flush_count", bus.flush_count, 64'(m_flushes));
`endif
    if (e_rd_en) m_retired++;
    if (e_flush) m_flushes++;
    m_wait = n_wait; m_flush = n_flush;
    m_redirect = n_redirect; m_mepc = n_mepc; m_mcause = n_mcause;
    @(negedge clk);
  endtask

  task automatic idle_head();
    bus.empty = 1; bus.head_ready = 0; bus.ROB_head_store = 0; bus.head_itype = 0;
    bus.head_rd = 0; bus.head_value = 0; bus.head_pc = 0; bus.head_target = 0;
    bus.head_branch_result = 0; bus.head_exception = 0; bus.head_mcause = 0;
    bus.head_rob = 0; bus.st_ack = 0; bus.st_err = 0;
  endtask

  // ---------------- single-cycle vector table ----------------
  typedef struct {
    bit          empty, ready;
    logic [1:0]  itype;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [3:0]  rob;
    bit          br;
    bit          x_rd_en, x_rf_we;
  } vec_t;

  vec_t vt[7];
  int   st_hi;

  initial begin
    vt[0] = '{1'b1, 1'b1, 2'b10, 5'd5,  32'h1111_1111, 4'd1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 2'b10, 5'd5,  32'h2222_2222, 4'd2, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 2'b10, 5'd5,  32'hDEAD_BEEF, 4'd3, 1'b0, 1'b1, 1'b1};
    vt[3] = '{1'b0, 1'b1, 2'b11, 5'd0,  32'h3333_3333, 4'd4, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b1, 2'b11, 5'd31, 32'hCAFE_F00D, 4'd15, 1'b0, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b1, 2'b00, 5'd7,  32'h4444_4444, 4'd6, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1'b0, 1'b1, 2'b01, 5'd9,  32'h5555_5555, 4'd7, 1'b0, 1'b1, 1'b0};

    model_reset();
    idle_head();
    reset = 1;
    #12;
    chk("reset rd_en", bus.rd_en, 0);
    chk("reset st_req", bus.st_req, 0);
    chk("reset flush", bus.flush, 0);
    chk("reset redirect_pc", bus.redirect_pc, 0);
    chk("reset trap_mepc", bus.trap_mepc, 0);
    chk("reset trap_mcause", bus.trap_mcause, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);

    // Table-driven single-cycle retires
    foreach (vt[i]) begin
      idle_head();
      bus.empty = vt[i].empty; bus.head_ready = vt[i].ready;
      bus.head_itype = vt[i].itype; bus.head_rd = vt[i].rd;
      bus.head_value = vt[i].value; bus.head_rob = vt[i].rob;
      bus.head_branch_result = vt[i].br;
      #1;
      chk($sformatf("vec%0d rd_en", i), bus.rd_en, vt[i].x_rd_en);
      chk($sformatf("vec%0d rf_we", i), bus.rf_we, vt[i].x_rf_we);
      if (vt[i].x_rf_we) begin
        chk($sformatf("vec%0d rf_waddr", i), bus.rf_waddr, vt[i].rd);
        chk($sformatf("vec%0d rf_wdata", i), bus.rf_wdata, vt[i].value);
        chk($sformatf("vec%0d rf_wrob", i), bus.rf_wrob, vt[i].rob);
      end
      step();
    end

    // Branch mispredict -> one flush cycle to the target
    idle_head();
    bus.empty = 0; bus.head_ready = 1; bus.head_itype = 2'b00;
    bus.head_branch_result = 1; bus.head_target = 32'h0000_2000;
    #1; chk("mispredict rd_en", bus.rd_en, 1); chk("mispredict flush early", bus.flush, 0);
    step();
    idle_head();
    #1; chk("flush cycle", bus.flush, 1); chk("flush redirect", bus.redirect_pc, 32'h2000);
    chk("flush rd_en", bus.rd_en, 0);
    step();
    #1; chk("flush ends", bus.flush, 0); chk("redirect held", bus.redirect_pc, 32'h2000);
    step();

    // Store with ack delayed three cycles
    idle_head();
    bus.empty = 0; bus.head_ready = 1; bus.ROB_head_store = 1; bus.head_itype = 2'b10;
    bus.head_rd = 5'd3;
    #1; chk("store idle rd_en", bus.rd_en, 0); chk("store idle rf_we", bus.rf_we, 0);
    step();
    st_hi = 0;
    for (int k = 0; k < 3; k++) begin
      bus.st_ack = (k == 2);
      #1;
      if (bus.st_req === 1'b1) st_hi++;
      chk($sformatf("store wait%0d rd_en", k), bus.rd_en, (k == 2));
      step();
    end
    chk("st_req high cycles", st_hi, 3);
    idle_head();
    #1; chk("st_req dropped", bus.st_req, 0);
    step();

    // Store error -> illegal access, then trap on the re-marked head
    bus.empty = 0; bus.head_ready = 1; bus.ROB_head_store = 1;
    step();
    bus.st_ack = 1; bus.st_err = 1;
    #1; chk("err illegal_access_e", bus.illegal_access_e, 1); chk("err rd_en", bus.rd_en, 0);
    step();
    bus.st_ack = 0; bus.st_err = 0;
    bus.head_exception = 1; bus.head_mcause = 8'd2; bus.head_pc = 32'h40;
    #1; chk("trap rd_en", bus.rd_en, 1); chk("trap st_req", bus.st_req, 0);
    chk("illegal pulse ends", bus.illegal_access_e, 0);
    step();
    idle_head();
    #1; chk("trap flush", bus.flush, 1); chk("trap redirect", bus.redirect_pc, 32'h100);
    chk("trap_mcause", bus.trap_mcause, 8'd2); chk("trap_mepc", bus.trap_mepc, 32'h40);
    step();
    step();

    // Reset in the middle of a store wait
    bus.empty = 0; bus.head_ready = 1; bus.ROB_head_store = 1;
    step();
    #1; chk("pre-reset st_req", bus.st_req, 1);
    #2; reset = 1;
    #1; chk("async reset st_req", bus.st_req, 0);
`ifdef COMMIT_PERF_EN
    chk("reset retired_count", bus.retired_count, 0);
    chk("reset flush_count", bus.flush_count, 0);
`endif
    model_reset();
    idle_head();
    bus.st_ack = 1;
    @(negedge clk);
    reset = 0;
    #1; chk("late ack rd_en", bus.rd_en, 0); chk("late ack illegal", bus.illegal_access_e, 0);
    step();

    // Randomized run against the model
    for (int c = 0; c < 600; c++) begin
      bus.empty = ($urandom_range(0, 7) == 0);
      bus.head_ready = ($urandom_range(0, 3) != 0);
      bus.head_exception = ($urandom_range(0, 7) == 0);
      bus.ROB_head_store = ($urandom_range(0, 3) == 0);
      bus.head_itype = 2'($urandom_range(0, 3));
      bus.head_rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      bus.head_value = $urandom; bus.head_pc = $urandom; bus.head_target = $urandom;
      bus.head_branch_result = $urandom_range(0, 1);
      bus.head_mcause = 8'($urandom); bus.head_rob = 4'($urandom);
      bus.st_ack = ($urandom_range(0, 2) == 0);
      bus.st_err = ($urandom_range(0, 3) == 0);
      #1;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, meaning the redirect PC on an exception.
REQ-002 SHALL have parameter ROB_IDX_W, default 4, meaning the ROB index width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, meaning the asynchronous active-high reset.
REQ-005 SHALL have ports empty, head_ready, ROB_head_store, each input, 1, meaning the ROB status for the head entry.
REQ-006 SHALL have ports head_itype (input, 2), head_rd (input, 5), head_value (input, 32), head_pc (input, 32), head_target (input, 32), head_branch_result (input, 1, where 1 = mispredict), head_exception (input, 1), head_mcause (input, 8) and head_rob (input, ROB_IDX_W), meaning the head entry fields.
REQ-007 SHALL have port rd_en, output, 1, meaning dequeue the ROB head this cycle.
REQ-008 SHALL have ports rf_we (output, 1), rf_waddr (output, 5), rf_wdata (output, 32) and rf_wrob (output, ROB_IDX_W), meaning the architectural register write and the tag to clear.
REQ-009 SHALL have ports st_req (output, 1), st_ack (input, 1) and st_err (input, 1), meaning the store-buffer release handshake.
REQ-010 SHALL have port illegal_access_e, output, 1, meaning mark the ROB head as an exception.
REQ-011 SHALL have ports flush (output, 1) and redirect_pc (output, 32), meaning pipeline squash and fetch redirect.
REQ-012 SHALL have ports trap_mepc (output, 32) and trap_mcause (output, 8), meaning the values latched on a trap.

Function
REQ-013 SHALL implement FSM states IDLE, ST_WAIT, FLUSH and TRAP, and commit at most one entry per cycle.
REQ-014 SHALL, in IDLE with empty=1 or head_ready=0, hold all outputs low.
REQ-015 SHALL, in IDLE with head_ready=1, head_exception=0 and itype 1x, assert rd_en and rf_we in the same cycle, with rf_waddr=head_rd, rf_wdata=head_value and rf_wrob=head_rob.
REQ-016 SHALL force rf_we=0 when head_rd=0; rd_en still asserts.
REQ-017 SHALL, for a branch (itype 00) with head_branch_result=0, assert rd_en only.
REQ-018 SHALL, for a branch with head_branch_result=1, assert rd_en, register redirect_pc=head_target and enter FLUSH.
REQ-019 SHALL, in FLUSH, assert flush for exactly 1 cycle with rd_en=0, then return to IDLE.
REQ-020 SHALL, for a store (ROB_head_store=1), assert no rd_en, enter ST_WAIT and hold st_req=1 until st_ack.
REQ-021 SHALL, in ST_WAIT on st_ack=1 with st_err=0, assert rd_en that cycle, drop st_req and go to IDLE.
REQ-022 SHALL, in ST_WAIT on st_ack=1 with st_err=1, pulse illegal_access_e for 1 cycle with rd_en=0 and go to IDLE; the head is then re-evaluated as an exception.
REQ-023 SHALL, in IDLE with head_ready=1 and head_exception=1, assert rd_en, latch trap_mepc=head_pc and trap_mcause=head_mcause, and enter TRAP.
REQ-024 SHALL, in TRAP, assert flush for 1 cycle with redirect_pc=TRAP_VECTOR, then return to IDLE.
REQ-025 SHALL give exception priority over the itype decode; an excepting instruction never writes rf or issues st_req.
REQ-026 SHALL hold redirect_pc stable from FLUSH/TRAP entry until the next redirect.
REQ-027 SHALL compute rd_en combinationally from the current state and the inputs; flush, redirect_pc and trap_* are registered.

Reset
REQ-028 SHALL, on reset asserted (asynchronously), go to IDLE and clear the outputs: rd_en=0, rf_we=0, st_req=0, flush=0, illegal_access_e=0, redirect_pc=0, trap_mepc=0, trap_mcause=0.
REQ-029 SHALL, on reset in ST_WAIT, drop st_req immediately; a later st_ack SHALL be ignored in IDLE.

Configuration
REQ-030 SHALL, with COMMIT_PERF_EN defined, add output retired_count (64) and output flush_count (32): retired_count increments on every rd_en=1 cycle; flush_count increments on every flush=1 cycle; both wrap and are zero on reset.
REQ-031 SHALL, without COMMIT_PERF_EN, omit both ports and both counters entirely.

Verification
REQ-032 Bench SHALL cover: head itype 10, rd=5, value 32'hDEAD_BEEF, ready -> same cycle rd_en=1, rf_we=1, rf_waddr=5, rf_wdata=32'hDEAD_BEEF.
REQ-033 Bench SHALL cover: head rd=0, itype 11, ready -> rd_en=1, rf_we=0.
REQ-034 Bench SHALL cover: branch with head_branch_result=1 and target 32'h0000_2000 -> rd_en=1, next cycle flush=1 with redirect_pc=32'h0000_2000, following cycle flush=0.
REQ-035 Bench SHALL cover: store ready with st_ack delayed 3 cycles -> st_req high 3 cycles, rd_en=1 only in the ack cycle.
REQ-036 Bench SHALL cover: store with st_ack=1 and st_err=1 -> illegal_access_e pulse; next cycle head_exception=1, mcause=2, pc=32'h40 -> rd_en=1, trap_mcause=2, trap_mepc=32'h40, then flush with redirect_pc=32'h100.
REQ-037 Bench SHALL cover: reset asserted mid-ST_WAIT -> st_req=0 immediately; with COMMIT_PERF_EN defined, retired_count=0.
